// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: register-file geometry and
// a popcount helper for the pending-register count.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH:0] pend_cnt_t;

  function automatic pend_cnt_t popcount(input logic [NUM_REGS-1:0] vec);
    pend_cnt_t n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + pend_cnt_t'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hazard_entry.sv
// One scoreboard slot: a pending bit and a latency countdown.
// An accepted issue beats writeback, and writeback beats the countdown.
module hazard_entry #(
  parameter int LAT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [LAT_WIDTH-1:0] set_lat,
  input  logic                 clr_en,
  output logic                 pending,
  output logic [LAT_WIDTH-1:0] count
);

  localparam logic [LAT_WIDTH-1:0] LAT_INF = '1;
  localparam logic [LAT_WIDTH-1:0] LAT_ONE = 1;

  logic                 pending_reg, pending_next;
  logic [LAT_WIDTH-1:0] count_reg, count_next;

  always_comb begin
    pending_next = pending_reg;
    count_next   = count_reg;
    if (set_en) begin
      // A re-issue to a pending register keeps the later of the two completions.
      pending_next = 1'b1;
      count_next   = (pending_reg && (count_reg > set_lat)) ? count_reg : set_lat;
    end else if (clr_en) begin
      pending_next = 1'b0;
      count_next   = '0;
    end else if (pending_reg && (count_reg != '0) && (count_reg != LAT_INF)) begin
      count_next = count_reg - LAT_ONE;
      if (count_reg == LAT_ONE) begin
        pending_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  assign pending = pending_reg;
  assign count   = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for the ID stage: flags RAW/WAW hazards against
// in-flight results and tracks how many issue cycles were stalled.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int LAT_WIDTH  = 3,
  parameter int STAT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_valid,
  input  logic                              issue_we,
  input  logic [REG_ADDR_WIDTH-1:0]         issue_rd,
  input  logic [LAT_WIDTH-1:0]              issue_lat,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SRC-1:0]                src_used,
  input  logic                              flush,
  input  logic                              wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]         wb_rd,
  input  logic                              clr_stats,
  output logic                              stall,
  output logic [NUM_SRC-1:0]                stall_src,
  output logic [REG_ADDR_WIDTH:0]           pending_cnt,
  output logic [STAT_WIDTH-1:0]             stall_cycles
);

  localparam logic [LAT_WIDTH-1:0]  LAT_INF  = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

  logic [NUM_REGS-1:0]  pend_vec;
  logic [LAT_WIDTH-1:0] cnt_arr [NUM_REGS];
  logic                 waw_hit;
  logic                 accept;
  logic [STAT_WIDTH-1:0] stall_cycles_reg, stall_cycles_next;

  // x0 is hardwired, so it never gets a slot.
  assign pend_vec[0] = 1'b0;
  assign cnt_arr[0]  = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      hazard_entry #(
        .LAT_WIDTH (LAT_WIDTH)
      ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept && (issue_rd == REG_ADDR_WIDTH'(gi))),
        .set_lat (issue_lat),
        .clr_en  (wb_valid && (wb_rd == REG_ADDR_WIDTH'(gi))),
        .pending (pend_vec[gi]),
        .count   (cnt_arr[gi])
      );
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign stall_src[gi] = src_used[gi]
                           && (src_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0)
                           && pend_vec[src_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
    end
  endgenerate

  // Only an unknown-latency producer blocks a later writer; finite ones are merged.
  assign waw_hit = issue_we && (issue_rd != '0) && pend_vec[issue_rd]
                && (cnt_arr[issue_rd] == LAT_INF);

  assign stall  = issue_valid && !flush && ((|stall_src) || waw_hit);
  assign accept = issue_valid && issue_we && (issue_rd != '0) && (issue_lat != '0)
               && !stall && !flush;

  assign pending_cnt = popcount(pend_vec);

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (clr_stats) begin
      stall_cycles_next = '0;
    end else if (stall && (stall_cycles_reg != '1)) begin
      stall_cycles_next = stall_cycles_reg + STAT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
    end else begin
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations are queued as stimulus
// is applied and popped against the DUT outputs a moment later.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NS = 2;
  localparam int LW = 3;
  localparam int SW = 4;
  localparam logic [LW-1:0] LINF = '1;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           issue_valid, issue_we, flush, wb_valid, clr_stats;
  logic [REG_ADDR_WIDTH-1:0]      issue_rd, wb_rd;
  logic [LW-1:0]                  issue_lat;
  logic [NS*REG_ADDR_WIDTH-1:0]   src_addr;
  logic [NS-1:0]                  src_used;
  logic                           stall;
  logic [NS-1:0]                  stall_src;
  logic [REG_ADDR_WIDTH:0]        pending_cnt;
  logic [SW-1:0]                  stall_cycles;

  hazard_scoreboard #(
    .NUM_SRC    (NS),
    .LAT_WIDTH  (LW),
    .STAT_WIDTH (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .src_addr     (src_addr),
    .src_used     (src_used),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .clr_stats    (clr_stats),
    .stall        (stall),
    .stall_src    (stall_src),
    .pending_cnt  (pending_cnt),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   stall_model = 0;

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h required=<queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      $display("txn %-14s observed=%0h expected=%0h", e.tag, obs, e.val);
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
    src_addr = '0; src_used = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; clr_stats = 1'b0;
  endtask

  task automatic set_issue(input logic we, input logic [4:0] rd, input logic [LW-1:0] lat,
                           input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    issue_valid = 1'b1; issue_we = we; issue_rd = rd; issue_lat = lat;
    src_addr = {s1, s0}; src_used = used;
  endtask

  // Combinational outputs for the current cycle, plus the stall-counter model.
  task automatic cyc(input string tag, input logic st, input logic [1:0] ss, input int pc);
    exp_push({tag, ".stall"}, 32'(st));
    exp_push({tag, ".src"},   32'(ss));
    exp_push({tag, ".pcnt"},  32'(pc));
    #1;
    chk(32'(stall));
    chk(32'(stall_src));
    chk(32'(pending_cnt));
    if (clr_stats) stall_model = 0;
    else if (st && stall_model < STAT_MAX) stall_model++;
  endtask

  task automatic stat_check(input string tag);
    exp_push(tag, 32'(stall_model));
    chk(32'(stall_cycles));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    cyc("rst", 1'b0, 2'b00, 0);
    stat_check("rst.stat");
    rst_n = 1'b1;
    tick();

    // RAW against a 2-cycle producer
    set_issue(1, 5, 2, 0, 0, 2'b00);      cyc("t1_iss", 0, 2'b00, 0);  tick();
    set_issue(0, 0, 0, 5, 0, 2'b01);      cyc("t1_raw_a", 1, 2'b01, 1); tick();
    cyc("t1_raw_b", 1, 2'b01, 1);         tick();
    cyc("t1_go", 0, 2'b00, 0);
    stat_check("t1_stat");
    idle(); tick();

    // Unknown latency: RAW and WAW held until writeback
    set_issue(1, 7, LINF, 0, 0, 2'b00);   cyc("t2_iss", 0, 2'b00, 0);  tick();
    set_issue(0, 0, 0, 0, 7, 2'b10);      cyc("t2_raw", 1, 2'b10, 1);  tick();
    set_issue(1, 7, 1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc("t2_waw", 1, 2'b00, 1);         tick();
    end
    wb_valid = 1'b1; wb_rd = 7;           cyc("t2_wb", 1, 2'b00, 1);   tick();
    wb_valid = 1'b0;                      cyc("t2_rel", 0, 2'b00, 0);  tick();
    idle();                               cyc("t2_new", 0, 2'b00, 1);  tick();
    cyc("t2_done", 0, 2'b00, 0);
    stat_check("t2_stat");
    tick();

    // Issue and writeback to the same register: issue wins with its own latency
    set_issue(1, 3, 2, 0, 0, 2'b00);      cyc("t3_iss", 0, 2'b00, 0);  tick();
    set_issue(1, 3, 4, 0, 0, 2'b00);
    wb_valid = 1'b1; wb_rd = 3;           cyc("t3_same", 0, 2'b00, 1); tick();
    idle(); set_issue(0, 0, 0, 3, 0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc("t3_len", 1, 2'b01, 1);         tick();
    end
    cyc("t3_go", 0, 2'b00, 0);
    idle(); tick();

    // x0 never becomes pending
    set_issue(1, 0, 5, 0, 0, 2'b11);      cyc("t4_x0", 0, 2'b00, 0);   tick();
    idle();                               cyc("t4_none", 0, 2'b00, 0); tick();

    // flush masks the stall and the acceptance, older entry keeps counting
    set_issue(1, 9, 3, 0, 0, 2'b00);      cyc("t5_iss", 0, 2'b00, 0);  tick();
    set_issue(1, 10, 2, 9, 0, 2'b01); flush = 1'b1;
    cyc("t5_flush", 0, 2'b01, 1);         tick();
    flush = 1'b0; set_issue(0, 0, 0, 9, 0, 2'b01);
    cyc("t5_raw", 1, 2'b01, 1);           tick();
    cyc("t5_raw2", 1, 2'b01, 1);          tick();
    cyc("t5_go", 0, 2'b00, 0);
    stat_check("t5_stat");
    idle(); tick();

    // Saturation, then clear taking priority over a live stall
    set_issue(1, 11, LINF, 0, 0, 2'b00);  cyc("t5_inf", 0, 2'b00, 0);  tick();
    set_issue(0, 0, 0, 11, 0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      cyc("t5_sat", 1, 2'b01, 1);         tick();
    end
    stat_check("t5_sat_stat");
    clr_stats = 1'b1;                     cyc("t5_clr", 1, 2'b01, 1);  tick();
    clr_stats = 1'b0;
    stat_check("t5_clr_stat");
    wb_valid = 1'b1; wb_rd = 11;          cyc("t5_wb", 1, 2'b01, 1);   tick();
    idle();                               cyc("t5_free", 0, 2'b00, 0);
    stat_check("t5_after_clr");
    tick();

    // Asynchronous reset with three pending entries
    set_issue(1, 1, LINF, 0, 0, 2'b00);   cyc("t6_iss1", 0, 2'b00, 0); tick();
    set_issue(1, 2, LINF, 0, 0, 2'b00);   cyc("t6_iss2", 0, 2'b00, 1); tick();
    set_issue(1, 4, LINF, 0, 0, 2'b00);   cyc("t6_iss4", 0, 2'b00, 2); tick();
    idle(); set_issue(0, 0, 0, 1, 0, 2'b01);
    cyc("t6_raw", 1, 2'b01, 3);
    #2;
    rst_n = 1'b0;
    stall_model = 0;
    cyc("t6_async", 0, 2'b00, 0);
    stat_check("t6_stat");
    rst_n = 1'b1;
    set_issue(1, 6, 1, 0, 0, 2'b00);      cyc("t6_rel_iss", 0, 2'b00, 0); tick();
    idle();                               cyc("t6_after", 0, 2'b00, 1);   tick();
    cyc("t6_end", 0, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, meaning the number of source operands checked per issued instruction.
REQ-002 The block SHALL have parameter LAT_WIDTH, default 3, meaning the latency counter width; the all-ones value LAT_INF marks an unknown latency that is released only at writeback.
REQ-003 The block SHALL have parameter STAT_WIDTH, default 32, meaning the stall statistic counter width.
REQ-004 The block SHALL take REG_ADDR_WIDTH (5) from the shared defines file; NUM_REGS = 2^REG_ADDR_WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port issue_valid, input, 1 bit: ID presents an instruction this cycle.
REQ-008 The block SHALL have port issue_we, input, 1 bit: the issued instruction writes issue_rd.
REQ-009 The block SHALL have port issue_rd, input, REG_ADDR_WIDTH bits: the destination register.
REQ-010 The block SHALL have port issue_lat, input, LAT_WIDTH bits: cycles until the result is forwardable; 0 means no hazard; LAT_INF means unknown latency.
REQ-011 The block SHALL have port src_addr, input, NUM_SRC*REG_ADDR_WIDTH bits: source register addresses, with source i in bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
REQ-012 The block SHALL have port src_used, input, NUM_SRC bits: per-source read-enable.
REQ-013 The block SHALL have port flush, input, 1 bit: squash the instruction currently in ID.
REQ-014 The block SHALL have port wb_valid, input, 1 bit: writeback completes this cycle.
REQ-015 The block SHALL have port wb_rd, input, REG_ADDR_WIDTH bits: the writeback destination.
REQ-016 The block SHALL have port clr_stats, input, 1 bit: synchronously clear stall_cycles.
REQ-017 The block SHALL have port stall, output, 1 bit: hold ID; the issue is not accepted.
REQ-018 The block SHALL have port stall_src, output, NUM_SRC bits: per-source RAW hit.
REQ-019 The block SHALL have port pending_cnt, output, REG_ADDR_WIDTH+1 bits: the number of pending registers.
REQ-020 The block SHALL have port stall_cycles, output, STAT_WIDTH bits: a saturating count of stalled issue cycles.

Function
REQ-021 The block SHALL keep, per register r, a pending bit P[r] and a counter C[r]; register x0 is never pending.
REQ-022 stall_src[i] SHALL be the combinational value of src_used[i] & (src_addr[i]!=0) & P[src_addr[i]].
REQ-023 stall SHALL be the combinational value of issue_valid & !flush & (|stall_src | WAW), where WAW = issue_we & (issue_rd!=0) & P[issue_rd] & (C[issue_rd]==LAT_INF).
REQ-024 An issue SHALL be accepted when issue_valid & issue_we & (issue_rd!=0) & (issue_lat!=0) & !stall & !flush.
REQ-025 On acceptance, P[issue_rd] SHALL be set to 1 and C[issue_rd] to max(C[issue_rd], issue_lat) if already pending, otherwise to issue_lat.
REQ-026 Each cycle, every pending entry with 0<C<LAT_INF not being written by an accepted issue SHALL decrement; an entry whose C goes 1->0 SHALL clear P in the same edge.
REQ-027 wb_valid with wb_rd matching a pending entry SHALL clear P and C for that entry, regardless of C.
REQ-028 When an accepted issue and wb_valid target the same register in one cycle, the issue SHALL win.
REQ-029 flush SHALL suppress acceptance and stall only; existing entries are older and SHALL continue counting.
REQ-030 pending_cnt SHALL be the popcount of P, combinational from registered state.
REQ-031 stall_cycles SHALL increment by 1 on each cycle with stall=1 and saturate at all-ones.
REQ-032 clr_stats SHALL zero stall_cycles and take priority over the increment.
REQ-033 Accepted latency SHALL equal RAW stall length: a consumer in ID on the cycle after issue sees stall for issue_lat cycles, then proceeds.

Reset
REQ-034 While rst_n=0, all P, all C and stall_cycles SHALL be 0 immediately; consequently stall=0, stall_src=0 and pending_cnt=0.
REQ-035 Reset deassertion mid-operation SHALL discard all in-flight entries, and the first edge after release SHALL accept issues normally.

Structure
REQ-036 REG_ADDR_WIDTH SHALL live in the shared defines file; LAT_INF SHALL be derived locally from LAT_WIDTH.
REQ-037 One sub-module, hazard_entry, SHALL hold one P/C pair with its set, decrement and clear logic, and SHALL be instantiated NUM_REGS-1 times for x1..x31.

Verification
REQ-038 Issue rd=5, lat=2; next cycle src0=5 used -> stall=1 for 2 cycles, then 0; pending_cnt 1->0.
REQ-039 Issue rd=7, lat=LAT_INF; a later issue with src1=7 or rd=7 (WAW) -> stall held until wb_valid, wb_rd=7; it releases the cycle after.
REQ-040 Same cycle: wb_rd=3 clearing, plus accepted issue rd=3, lat=4 -> P[3]=1, C[3]=4.
REQ-041 rd=0 issue with lat=5, and src_addr=0 used -> never pending, stall=0.
REQ-042 Stalls with flush=1 during a RAW hit -> stall=0 and no new entry; stall_cycles counts only non-flush stalls; preloaded near all-ones -> saturates; clr_stats -> 0.
REQ-043 Assert rst_n=0 asynchronously with 3 pending entries -> pending_cnt=0 and stall=0 before the next edge.
